// File: rtl/apb_mem_pkg.sv
// Shared definitions for the APB requester/responder pair.
package apb_mem_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int MAX_WAIT = 7;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  // Transfer FSM encoding, kept as plain constants so legacy code can compare raw values.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter; done flags the last counted cycle (value == 1).
module apb_wait_counter import apb_mem_pkg::*; #(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         done
);

  // Load has priority; otherwise count down while enabled, saturating at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign done = (value == W'(1));

endmodule

// File: rtl/apb_mem_responder.sv
// APB memory completer: DEPTH-word register file, programmable wait states,
// error response for misaligned or out-of-range addresses.
module apb_mem_responder #(
  parameter int ADDR_W   = apb_mem_pkg::ADDR_W,
  parameter int DATA_W   = apb_mem_pkg::DATA_W,
  parameter int DEPTH    = apb_mem_pkg::DEPTH,
  parameter int MAX_WAIT = apb_mem_pkg::MAX_WAIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [ADDR_W-1:0]             paddr_i,
  input  logic [DATA_W-1:0]             pwdata_i,
  input  logic [$clog2(MAX_WAIT+1)-1:0] wait_cfg_i,
  output logic                          pready_o,
  output logic [DATA_W-1:0]             prdata_o,
  output logic                          pslverr_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WRD_W = ADDR_W - 2;
  localparam logic [WRD_W-1:0] DEPTH_LIM = WRD_W'(DEPTH);

  import apb_mem_pkg::*;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                setup;
  logic [ADDR_W-1:0]   xfer_addr;
  logic                xfer_write;
  logic                err;
  logic [IDX_W-1:0]    idx;
  logic                enter_resp;
  logic                cnt_load;
  logic                cnt_en;
  logic                cnt_done;
  logic [CNT_W-1:0]    cnt_value;

  apb_wait_counter #(.W(CNT_W)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (wait_cfg_i),
    .value      (cnt_value),
    .done       (cnt_done)
  );

  // With zero wait states the response is registered on the setup edge itself,
  // so the live bus inputs stand in for the not-yet-latched copies.
  always_comb begin
    setup      = (state == ST_IDLE) && psel_i && !penable_i;
    xfer_addr  = (state == ST_IDLE) ? paddr_i  : addr_q;
    xfer_write = (state == ST_IDLE) ? pwrite_i : write_q;
    err        = (xfer_addr[1:0] != 2'b00) || (xfer_addr[ADDR_W-1:2] >= DEPTH_LIM);
    idx        = xfer_addr[IDX_W+1:2];
    enter_resp = (setup && (wait_cfg_i == '0)) ||
                 ((state == ST_WAIT) && psel_i && cnt_done);
    cnt_load   = setup && (wait_cfg_i != '0);
    cnt_en     = (state == ST_WAIT);
  end

  // Transfer sequencing and capture of the setup-phase request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            state   <= (wait_cfg_i == '0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!psel_i) begin
            state <= ST_IDLE;
          end else if (cnt_done) begin
            state <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered response: one-cycle pready pulse with error and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      pready_o  <= enter_resp;
      pslverr_o <= enter_resp && err;
      prdata_o  <= (enter_resp && !xfer_write && !err) ? mem[idx] : '0;
    end
  end

  // Memory: cleared on reset, written at the end of an error-free write response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((state == ST_RESP) && write_q && !err) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Randomized and directed bench for apb_mem_responder against a word-array model.
module tb_apb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [2:0]  wait_cfg;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [16];

  always #5 clk = ~clk;

  apb_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .MAX_WAIT(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .psel_i     (psel),
    .penable_i  (penable),
    .pwrite_i   (pwrite),
    .paddr_i    (paddr),
    .pwdata_i   (pwdata),
    .wait_cfg_i (wait_cfg),
    .pready_o   (pready),
    .prdata_o   (prdata),
    .pslverr_o  (pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_err(input logic [9:0] a);
    int word;
    word = int'(a) / 4;
    return (int'(a) % 4 != 0) || (word >= 16);
  endfunction

  function automatic int word_of(input logic [9:0] a);
    return int'(a) / 4;
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0;
      penable = 1'b0;
      check("pready_idle", {31'd0, pready}, 32'd0);
    end
  endtask

  // One complete transfer; access-phase inputs are scrambled to show they are ignored.
  task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] d, input int w);
    int  lat;
    bit  seen;
    bit  e;
    @(negedge clk);
    check("pready_setup", {31'd0, pready}, 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cfg = 3'(w);
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      penable  = 1'b1;
      paddr    = 10'($urandom);
      pwdata   = $urandom;
      pwrite   = 1'($urandom);
      wait_cfg = 3'($urandom);
      if (pready) begin
        seen = 1'b1;
        lat = k;
      end
    end
    e = addr_err(a);
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), 32'(w + 1));
      check("pslverr", {31'd0, pslverr}, {31'd0, e});
      if (!wr) check("prdata", prdata, e ? 32'd0 : ref_mem[word_of(a)]);
    end
    if (wr && !e) ref_mem[word_of(a)] = d;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] a;
    int r;
    reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg = '0;
    clear_ref();
    repeat (2) @(negedge clk);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    reset = 1'b1;

    xfer(0, 10'h004, 32'd0, 0);

    // Zero-wait write then read, and a wait-state read followed by a quiet cycle.
    xfer(1, 10'h008, 32'hDEADBEEF, 0);
    xfer(0, 10'h008, 32'd0, 0);
    xfer(0, 10'h008, 32'd0, 3);
    idle(2);

    // Error responses leave memory untouched (index 16 must not alias word 0).
    xfer(1, 10'h040, 32'h12345678, 0);
    xfer(1, 10'h005, 32'hCAFEF00D, 1);
    xfer(0, 10'h040, 32'd0, 0);
    xfer(0, 10'h000, 32'd0, 0);
    xfer(0, 10'h3FC, 32'd0, 2);

    // Back-to-back with no idle cycles.
    xfer(1, 10'h000, 32'h1, 0);
    xfer(1, 10'h03C, 32'hF, 0);
    xfer(0, 10'h000, 32'd0, 0);
    xfer(0, 10'h03C, 32'd0, 0);
    xfer(1, 10'h020, 32'h5555AAAA, 4);
    xfer(0, 10'h020, 32'd0, 7);
    idle(1);

    // Abort: psel drops in the second wait cycle; no response, no write.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h010; pwdata = 32'hA5A5A5A5; wait_cfg = 3'd5;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    idle(10);
    xfer(0, 10'h010, 32'd0, 0);

    // Asynchronous reset while pready is high.
    xfer(1, 10'h014, 32'h0BADF00D, 0);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h014; wait_cfg = 3'd0;
    @(negedge clk);
    penable = 1'b1;
    check("pre_rst_pready", {31'd0, pready}, 32'd1);
    check("pre_rst_prdata", prdata, 32'h0BADF00D);
    #1 reset = 1'b0;
    #1;
    check("async_rst_pready", {31'd0, pready}, 32'd0);
    check("async_rst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_ref();
    xfer(0, 10'h014, 32'd0, 0);

    // Reset in the middle of a wait phase.
    xfer(1, 10'h018, 32'h13579BDF, 0);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h01C; pwdata = 32'h2468ACE0; wait_cfg = 3'd5;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("wait_rst_pready", {31'd0, pready}, 32'd0);
    check("wait_rst_pslverr", {31'd0, pslverr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_ref();
    idle(8);
    xfer(0, 10'h018, 32'd0, 0);
    xfer(0, 10'h01C, 32'd0, 1);

    // Randomized traffic with occasional gaps.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 10'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 10'($urandom_range(16, 255) * 4);
      else             a = 10'($urandom);
      xfer(1'($urandom), a, $urandom, $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
